// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: walker state encoding, counter
// initial value and the parameter legality rule.
package branch_predictor_pkg;

    typedef enum logic [0:0] {
        BP_INIT  = 1'b0,
        BP_READY = 1'b1
    } bp_state_e;

    function automatic int bp_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Weakly not-taken: all ones below the MSB.
    function automatic logic [3:0] bp_ctr_init(input int w);
        return 4'((32'd1 << (w - 1)) - 32'd1);
    endfunction

    function automatic logic bp_params_ok(input int ghr_width, input int pht_bits,
                                          input int ctr_width);
        return (ghr_width >= 0) && (ghr_width <= pht_bits) &&
               (ctr_width >= 1) && (ctr_width <= 4);
    endfunction

endpackage

// File: rtl/branch_predictor_init_walker.sv
// Table-initialisation walker: sweeps every PHT/BTB index once after reset or
// flush and raises ready when the sweep completes.
module branch_predictor_init_walker
    import branch_predictor_pkg::*;
#(
    parameter int PHT_INDEX_BITS = 8,
    parameter int BTB_INDEX_BITS = 6,
    localparam int IDX_BITS = bp_max(PHT_INDEX_BITS, BTB_INDEX_BITS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_req,
    output logic                ready,
    output logic                pht_clr_en,
    output logic                btb_clr_en,
    output logic [IDX_BITS-1:0] clr_idx
);

    localparam logic [IDX_BITS-1:0] IDX_LAST = '1;

    bp_state_e           state_r;
    logic [IDX_BITS-1:0] idx_r;
    logic                ready_r;
    logic                walking_s;

    // Walker FSM: INIT sweeps idx, READY waits for a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= BP_INIT;
            idx_r   <= '0;
            ready_r <= 1'b0;
        end else begin
            case (state_r)
                BP_INIT: begin
                    if (flush_req) begin
                        idx_r <= '0;
                    end else if (idx_r == IDX_LAST) begin
                        state_r <= BP_READY;
                        ready_r <= 1'b1;
                        idx_r   <= '0;
                    end else begin
                        idx_r <= idx_r + IDX_BITS'(1'b1);
                    end
                end
                BP_READY: begin
                    if (flush_req) begin
                        state_r <= BP_INIT;
                        ready_r <= 1'b0;
                        idx_r   <= '0;
                    end
                end
                default: begin
                    state_r <= BP_INIT;
                    ready_r <= 1'b0;
                    idx_r   <= '0;
                end
            endcase
        end
    end

    assign walking_s = (state_r == BP_INIT);
    assign ready     = ready_r;
    assign clr_idx   = idx_r;

    // The smaller table only takes writes while the upper idx bits are zero.
    if (PHT_INDEX_BITS == IDX_BITS) begin : g_pht_full
        assign pht_clr_en = walking_s;
    end else begin : g_pht_part
        assign pht_clr_en = walking_s && (idx_r[IDX_BITS-1:PHT_INDEX_BITS] == '0);
    end

    if (BTB_INDEX_BITS == IDX_BITS) begin : g_btb_full
        assign btb_clr_en = walking_s;
    end else begin : g_btb_part
        assign btb_clr_en = walking_s && (idx_r[IDX_BITS-1:BTB_INDEX_BITS] == '0);
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage direction/target predictor: tagged BTB plus gshare (or bimodal)
// PHT of saturating counters, cleared by a sequential walker.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int ALIGN_BITS     = 2,
    parameter int PHT_INDEX_BITS = 8,
    parameter int BTB_INDEX_BITS = 6,
    parameter int TAG_WIDTH      = 8,
    parameter int CTR_WIDTH      = 2,
    parameter int GHR_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_req,
    output logic                  ready,
    input  logic [ADDR_WIDTH-1:0] cur_pc,
    output logic                  pred_taken,
    output logic                  pred_hit,
    output logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [ADDR_WIDTH-1:0] upd_target
);

    localparam int PHT_SIZE = 1 << PHT_INDEX_BITS;
    localparam int BTB_SIZE = 1 << BTB_INDEX_BITS;
    localparam int IDX_BITS = bp_max(PHT_INDEX_BITS, BTB_INDEX_BITS);
    localparam int GHR_W    = (GHR_WIDTH > 0) ? GHR_WIDTH : 1;
    localparam int TAG_LSB  = ALIGN_BITS + BTB_INDEX_BITS;
    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
    localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'(bp_ctr_init(CTR_WIDTH));

    if (!bp_params_ok(GHR_WIDTH, PHT_INDEX_BITS, CTR_WIDTH)) begin : g_param_check
        $error("branch_predictor: GHR_WIDTH must be <= PHT_INDEX_BITS and CTR_WIDTH in 1..4");
    end

    logic [CTR_WIDTH-1:0]      pht_r       [PHT_SIZE];
    logic                      btb_valid_r [BTB_SIZE];
    logic [TAG_WIDTH-1:0]      btb_tag_r   [BTB_SIZE];
    logic [ADDR_WIDTH-1:0]     btb_tgt_r   [BTB_SIZE];
    logic [GHR_W-1:0]          ghr_r;

    logic                      pht_clr_en_s;
    logic                      btb_clr_en_s;
    logic [IDX_BITS-1:0]       clr_idx_s;
    logic [PHT_INDEX_BITS-1:0] ghr_ext_s;
    logic [PHT_INDEX_BITS-1:0] lk_pht_idx_s;
    logic [BTB_INDEX_BITS-1:0] lk_btb_idx_s;
    logic [TAG_WIDTH-1:0]      lk_tag_s;
    logic [PHT_INDEX_BITS-1:0] up_pht_idx_s;
    logic [BTB_INDEX_BITS-1:0] up_btb_idx_s;
    logic [TAG_WIDTH-1:0]      up_tag_s;
    logic                      up_en_s;
    logic [CTR_WIDTH-1:0]      up_ctr_s;
    logic [CTR_WIDTH-1:0]      up_ctr_next_s;
    logic                      hit_s;
    logic                      taken_s;
    logic                      pc_unused_s;

    branch_predictor_init_walker #(
        .PHT_INDEX_BITS (PHT_INDEX_BITS),
        .BTB_INDEX_BITS (BTB_INDEX_BITS)
    ) u_walker (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_req  (flush_req),
        .ready      (ready),
        .pht_clr_en (pht_clr_en_s),
        .btb_clr_en (btb_clr_en_s),
        .clr_idx    (clr_idx_s)
    );

    if (GHR_WIDTH == 0) begin : g_bimodal
        assign ghr_ext_s = '0;
    end else if (GHR_WIDTH == PHT_INDEX_BITS) begin : g_gshare_full
        assign ghr_ext_s = ghr_r;
    end else begin : g_gshare_part
        assign ghr_ext_s = {{(PHT_INDEX_BITS - GHR_W){1'b0}}, ghr_r};
    end

    assign lk_pht_idx_s = cur_pc[ALIGN_BITS +: PHT_INDEX_BITS] ^ ghr_ext_s;
    assign lk_btb_idx_s = cur_pc[ALIGN_BITS +: BTB_INDEX_BITS];
    assign lk_tag_s     = cur_pc[TAG_LSB +: TAG_WIDTH];
    assign up_pht_idx_s = upd_pc[ALIGN_BITS +: PHT_INDEX_BITS] ^ ghr_ext_s;
    assign up_btb_idx_s = upd_pc[ALIGN_BITS +: BTB_INDEX_BITS];
    assign up_tag_s     = upd_pc[TAG_LSB +: TAG_WIDTH];
    assign pc_unused_s  = ^{upd_pc, clr_idx_s, ghr_r};

    // Flush takes priority over a same-cycle update.
    assign up_en_s = upd_valid && ready && !flush_req;

    // Combinational lookup; a not-ready predictor always falls through.
    always_comb begin
        hit_s   = 1'b0;
        taken_s = 1'b0;
        if (ready) begin
            hit_s   = btb_valid_r[lk_btb_idx_s] && (btb_tag_r[lk_btb_idx_s] == lk_tag_s);
            taken_s = pht_r[lk_pht_idx_s][CTR_WIDTH-1] && hit_s;
        end else begin
            hit_s   = 1'b0;
            taken_s = 1'b0;
        end
        pred_hit    = hit_s;
        pred_taken  = taken_s;
        pred_target = taken_s ? btb_tgt_r[lk_btb_idx_s] : (cur_pc + ADDR_WIDTH'(32'd4));
    end

    // Saturating counter step for the resolved branch.
    always_comb begin
        up_ctr_s      = pht_r[up_pht_idx_s];
        up_ctr_next_s = up_ctr_s;
        if (upd_taken) begin
            if (up_ctr_s == CTR_MAX) begin
                up_ctr_next_s = up_ctr_s;
            end else begin
                up_ctr_next_s = up_ctr_s + CTR_WIDTH'(1'b1);
            end
        end else begin
            if (up_ctr_s == '0) begin
                up_ctr_next_s = up_ctr_s;
            end else begin
                up_ctr_next_s = up_ctr_s - CTR_WIDTH'(1'b1);
            end
        end
    end

    // Table write ports (no reset so they map onto RAM); walker clears win.
    always_ff @(posedge clk) begin
        if (pht_clr_en_s) begin
            pht_r[clr_idx_s[PHT_INDEX_BITS-1:0]] <= CTR_INIT;
        end else if (up_en_s) begin
            pht_r[up_pht_idx_s] <= up_ctr_next_s;
        end
        if (btb_clr_en_s) begin
            btb_valid_r[clr_idx_s[BTB_INDEX_BITS-1:0]] <= 1'b0;
        end else if (up_en_s && upd_taken) begin
            btb_valid_r[up_btb_idx_s] <= 1'b1;
            btb_tag_r[up_btb_idx_s]   <= up_tag_s;
            btb_tgt_r[up_btb_idx_s]   <= upd_target;
        end
    end

    // Global history: held at zero outside READY, shifts on each update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_r <= '0;
        end else if ((GHR_WIDTH == 0) || !ready || flush_req) begin
            ghr_r <= '0;
        end else if (up_en_s) begin
            ghr_r <= (ghr_r << 1) | GHR_W'(upd_taken);
        end
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised successor to the fetch-stage direction/target predictor. It combines a tagged, valid-qualified BTB with a gshare (or bimodal) pattern history table of configurable-width saturating counters. A sequential table-initialisation walker runs after reset or a flush request. Lookup is combinational from fetch PC; update comes registered from the branch-resolve stage.

## Interface
- ADDR_WIDTH, 32, PC/target width
- ALIGN_BITS, 2, low PC bits dropped before indexing
- PHT_INDEX_BITS, 8, log2 PHT entries
- BTB_INDEX_BITS, 6, log2 BTB entries
- TAG_WIDTH, 8, BTB tag width; tag = pc[ALIGN_BITS+BTB_INDEX_BITS +: TAG_WIDTH]
- CTR_WIDTH, 2, counter width, 1..4
- GHR_WIDTH, 8, global history length; 0 = bimodal; must be ≤ PHT_INDEX_BITS
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- flush_req  in  1  one-cycle pulse; reinitialise all tables
- ready  out  1  tables valid; predictions and updates honoured
- cur_pc  in  ADDR_WIDTH  fetch PC for lookup
- pred_taken  out  1  predicted taken
- pred_hit  out  1  BTB tag hit with valid entry
- pred_target  out  ADDR_WIDTH  next-PC prediction
- upd_valid  in  1  resolved branch this cycle
- upd_pc  in  ADDR_WIDTH  resolved branch PC
- upd_taken  in  1  actual direction
- upd_target  in  ADDR_WIDTH  actual taken target

## Operation
- PHT index = pc[ALIGN_BITS +: PHT_INDEX_BITS] XOR zero-extended GHR. GHR_WIDTH=0 gives a pure PC index.
- BTB index = pc[ALIGN_BITS +: BTB_INDEX_BITS]. Entry = {valid, tag, target}.
- Counter init value = 2^(CTR_WIDTH-1)-1 (weakly not-taken). Predict taken iff counter MSB = 1.
- Lookup (ready=1):
  - pred_hit = valid && tag match.
  - pred_taken = counter MSB && pred_hit.
  - pred_target = pred_taken ? BTB target : cur_pc+4, modulo 2^ADDR_WIDTH.
- Lookup (ready=0): pred_hit=0, pred_taken=0, pred_target=cur_pc+4.
- Update (upd_valid && ready):
  - PHT counter at the upd_pc index, formed with the current GHR, increments if taken, else decrements. It saturates at 0 and at 2^CTR_WIDTH-1.
  - If taken: BTB entry ← {1, tag(upd_pc), upd_target}, overwriting on tag conflict. If not taken: BTB unchanged.
  - GHR ← {GHR[GHR_WIDTH-2:0], upd_taken}.
- Init walker FSM, states INIT and READY:
  - INIT: idx runs 0 to 2^max(PHT_INDEX_BITS,BTB_INDEX_BITS)-1, one entry per cycle. It writes the counter init value where idx < PHT size, and valid=0 where idx < BTB size. GHR is held at 0.
  - INIT→READY on the cycle after the last idx is written.
  - READY→INIT on flush_req; idx resets to 0.
- Boundary cases:
  - flush_req during INIT restarts the walk at idx 0.
  - flush_req and upd_valid in the same cycle: flush wins, update dropped.
  - upd_valid while ready=0: ignored.
  - Lookup and update to the same entry in one cycle: lookup sees the pre-update value.
  - Index arithmetic wraps naturally. A tag mismatch is never a hit.

## Timing
- Reset (rst_n low, async): state=INIT, idx=0, GHR=0, ready=0. Outputs take the ready=0 values above.
- Arrays are not reset directly; the walker clears them. This keeps them RAM-inferable.
- Deassert mid-walk is irrelevant: reset always restarts the walk.
- ready rises 2^max(PHT_INDEX_BITS,BTB_INDEX_BITS) cycles after rst_n deasserts or after the flush_req cycle. With defaults that is 256 cycles.
- Lookup latency 0 (combinational). Update visible to lookup on the next cycle.
- GHR change is visible to the next-cycle index.

## Structure
- common.vh holds:
  - FSM state encodings BP_INIT and BP_READY
  - `define BP_CTR_INIT(w)
  - the parameter legality check (GHR_WIDTH ≤ PHT_INDEX_BITS, CTR_WIDTH 1..4), reported via $error in an initial block
- Sub-module bp_init_walker: owns state, idx and ready. Emits per-cycle PHT/BTB clear-write enables and the index.
- Top level holds the arrays, GHR, lookup and update logic.

## Test plan
- Reset and walk: deassert rst_n, lookup cur_pc=0x100 each cycle → ready=0 and pred_target=0x104 for 256 cycles, then ready=1 with pred_hit=0.
- Training with GHR_WIDTH=0: 2 taken updates, upd_pc=0x40, upd_target=0x80 → lookup 0x40 gives pred_hit=1, pred_taken=1, pred_target=0x80.
- Saturation and decay: 5 taken then 2 not-taken at 0x40 → pred_taken=0 after the 2nd not-taken. A further 5 not-taken leave the counter at 0, with no underflow.
- Tag conflict: train 0x40 taken, then 0x140 (same BTB index, different tag) taken → lookup 0x40 gives pred_hit=0 and target 0x44.
- Gshare aliasing: GHR_WIDTH=8, alternate taken/not-taken updates at one PC for 32 iterations → GHR=0xAA or 0x55 as expected, and the PHT index differs per history.
- Flush and collision: flush_req with upd_valid in the same cycle → update dropped, ready=0 for 256 cycles. A 2nd flush_req at cycle 100 restarts the walk, giving a full 256 cycles from that point.
